// File: rtl/bagman_load_pkg.sv
// Shared types and ROM map constants for the Bagman ROM download sequencer.
package bagman_load_pkg;

  typedef enum logic [1:0] {
    S_BOOT,
    S_LOAD,
    S_HOLD,
    S_RUN
  } state_e;

  localparam int unsigned CPU_BASE  = 32'h0000_0000;
  localparam int unsigned GFX_BASE  = 32'h0000_6000;
  localparam int unsigned SPCH_BASE = 32'h0000_A000;
  localparam int unsigned IMG_END   = 32'h0000_C000;

  localparam int unsigned RGN_W    = 3;
  localparam int unsigned RGN_CPU  = 0;
  localparam int unsigned RGN_GFX  = 1;
  localparam int unsigned RGN_SPCH = 2;

endpackage

// File: rtl/rom_load_sequencer_if.sv
// ioctl download port in, dn_* ROM write port and load status out.
interface rom_load_if
  import bagman_load_pkg::*;
#(
  parameter int unsigned CNT_W = 17
);
  logic             ioctl_download;
  logic             ioctl_wr;
  logic [24:0]      ioctl_addr;
  logic [7:0]       ioctl_dout;
  logic [CNT_W-1:0] dn_addr;
  logic [7:0]       dn_data;
  logic             dn_wr;
  logic [RGN_W-1:0] rgn_sel;
  logic             core_reset;
  logic             load_ok;
  logic             load_err;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  dn_addr, dn_data, dn_wr, rgn_sel, core_reset, load_ok, load_err
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output dn_addr, dn_data, dn_wr, rgn_sel, core_reset, load_ok, load_err
  );
endinterface

// File: rtl/rom_region_decode.sv
// Combinational ROM address to one-hot region decode.
module rom_region_decode
  import bagman_load_pkg::*;
#(
  parameter int unsigned AW = 17
) (
  input  logic [AW-1:0]    addr,
  output logic [RGN_W-1:0] rgn_sel
);
  logic [31:0] a32;
  assign a32 = 32'(addr);

  // Regions are contiguous from CPU_BASE; anything past IMG_END decodes to none.
  always_comb begin
    rgn_sel = '0;
    if (a32 < GFX_BASE) begin
      rgn_sel[RGN_CPU] = 1'b1;
    end else if (a32 < SPCH_BASE) begin
      rgn_sel[RGN_GFX] = 1'b1;
    end else if (a32 < IMG_END) begin
      rgn_sel[RGN_SPCH] = 1'b1;
    end
  end
endmodule

// File: rtl/rom_load_sequencer.sv
// Forwards ioctl ROM writes to the core, checks the image and holds core reset.
module rom_load_sequencer
  import bagman_load_pkg::*;
#(
  parameter int unsigned EXPECT_BYTES = 49152,
  parameter int unsigned HOLD_CYC     = 1024,
  parameter int unsigned CNT_W        = 17
) (
  input logic       clk_sys,
  input logic       reset,
  rom_load_if.slave bus
);
  localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  state_e           state_q, state_d;
  logic             dl_q;
  logic [CNT_W-1:0] count_q, count_d, cnt_base;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic             ok_q, ok_d, err_q, err_d;
  logic             core_reset_q, core_reset_d;
  logic             dn_wr_q, dn_wr_d;
  logic [CNT_W-1:0] dn_addr_q, dn_addr_d;
  logic [7:0]       dn_data_q, dn_data_d;
  logic [RGN_W-1:0] rgn_q, rgn_d, rgn_dec;
  logic             rise, fall, hit;

  rom_region_decode #(.AW(CNT_W)) u_decode (
    .addr    (bus.ioctl_addr[CNT_W-1:0]),
    .rgn_sel (rgn_dec)
  );

  assign rise = bus.ioctl_download & ~dl_q;
  assign fall = ~bus.ioctl_download & dl_q;
  // A write coinciding with the rising edge is checked against a fresh count.
  assign cnt_base = rise ? '0 : count_q;
  assign hit = (32'(bus.ioctl_addr) == 32'(cnt_base)) && (32'(cnt_base) < EXPECT_BYTES);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hold_d    = hold_q;
    ok_d      = ok_q;
    err_d     = err_q;
    dn_wr_d   = 1'b0;
    dn_addr_d = dn_addr_q;
    dn_data_d = dn_data_q;
    rgn_d     = '0;

    if (rise) begin
      state_d = S_LOAD;
      count_d = '0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
    end

    if ((state_q == S_LOAD || rise) && bus.ioctl_wr) begin
      if (hit) begin
        dn_wr_d   = 1'b1;
        dn_addr_d = bus.ioctl_addr[CNT_W-1:0];
        dn_data_d = bus.ioctl_dout;
        rgn_d     = rgn_dec;
        count_d   = cnt_base + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    // The completeness check sees any write landing on the falling-edge cycle.
    unique case (state_q)
      S_LOAD: begin
        if (fall) begin
          if (32'(count_d) == EXPECT_BYTES && !err_d) ok_d = 1'b1;
          else err_d = 1'b1;
          state_d = S_HOLD;
          hold_d  = '0;
        end
      end
      S_HOLD: begin
        if (!rise) begin
          if (hold_q == HOLD_LAST) state_d = ok_q ? S_RUN : S_BOOT;
          else hold_d = hold_q + 1'b1;
        end
      end
      S_BOOT, S_RUN: ;
    endcase

    core_reset_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_BOOT;
      dl_q         <= 1'b0;
      count_q      <= '0;
      hold_q       <= '0;
      ok_q         <= 1'b0;
      err_q        <= 1'b0;
      core_reset_q <= 1'b1;
      dn_wr_q      <= 1'b0;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
      rgn_q        <= '0;
    end else begin
      state_q      <= state_d;
      dl_q         <= bus.ioctl_download;
      count_q      <= count_d;
      hold_q       <= hold_d;
      ok_q         <= ok_d;
      err_q        <= err_d;
      core_reset_q <= core_reset_d;
      dn_wr_q      <= dn_wr_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      rgn_q        <= rgn_d;
    end
  end

  assign bus.dn_wr      = dn_wr_q;
  assign bus.dn_addr    = dn_addr_q;
  assign bus.dn_data    = dn_data_q;
  assign bus.rgn_sel    = rgn_q;
  assign bus.core_reset = core_reset_q;
  assign bus.load_ok    = ok_q;
  assign bus.load_err   = err_q;
endmodule

// File: tb/tb_rom_load_sequencer.sv
// Directed bench: full-size instance for the full image, small instance for error paths.
module tb_rom_load_sequencer;
  import bagman_load_pkg::*;

  localparam int unsigned SB_BYTES = 512;
  localparam int unsigned SB_HOLD  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, sel, dl, wr;
  logic [24:0] addr;
  logic [7:0]  dout;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  int          c0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [16:0] a;
    logic [7:0]  d;
    logic [2:0]  r;
  } exp_t;
  exp_t sb[$];

  rom_load_if #(.CNT_W(17)) bus_a ();
  rom_load_if #(.CNT_W(17)) bus_b ();

  rom_load_sequencer #(.EXPECT_BYTES(49152), .HOLD_CYC(1024), .CNT_W(17)) dut_a (
    .clk_sys (clk),
    .reset   (rst_a),
    .bus     (bus_a.slave)
  );

  rom_load_sequencer #(.EXPECT_BYTES(SB_BYTES), .HOLD_CYC(SB_HOLD), .CNT_W(17)) dut_b (
    .clk_sys (clk),
    .reset   (rst_b),
    .bus     (bus_b.slave)
  );

  assign bus_a.ioctl_download = sel ? 1'b0 : dl;
  assign bus_a.ioctl_wr       = sel ? 1'b0 : wr;
  assign bus_a.ioctl_addr     = addr;
  assign bus_a.ioctl_dout     = dout;
  assign bus_b.ioctl_download = sel ? dl : 1'b0;
  assign bus_b.ioctl_wr       = sel ? wr : 1'b0;
  assign bus_b.ioctl_addr     = addr;
  assign bus_b.ioctl_dout     = dout;

  logic        o_wr, o_rst, o_ok, o_err;
  logic [16:0] o_addr;
  logic [7:0]  o_data;
  logic [2:0]  o_rgn;
  logic [1:0]  o_state;
  assign o_wr    = sel ? bus_b.dn_wr      : bus_a.dn_wr;
  assign o_rst   = sel ? bus_b.core_reset : bus_a.core_reset;
  assign o_ok    = sel ? bus_b.load_ok    : bus_a.load_ok;
  assign o_err   = sel ? bus_b.load_err   : bus_a.load_err;
  assign o_addr  = sel ? bus_b.dn_addr    : bus_a.dn_addr;
  assign o_data  = sel ? bus_b.dn_data    : bus_a.dn_data;
  assign o_rgn   = sel ? bus_b.rgn_sel    : bus_a.rgn_sel;
  assign o_state = sel ? dut_b.state_q    : dut_a.state_q;

  function automatic logic [2:0] exp_rgn(input int a);
    if (a < 'h6000) return 3'b001;
    if (a < 'hA000) return 3'b010;
    if (a < 'hC000) return 3'b100;
    return 3'b000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic run_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wr_byte(input int a, input bit acc);
    wr   = 1'b1;
    addr = 25'(a);
    dout = 8'(a * 7 + 3);
    if (acc) sb.push_back('{cyc + 1, 17'(a), 8'(a * 7 + 3), exp_rgn(a)});
    tick();
    wr = 1'b0;
  endtask

  task automatic load_seq(input int first, input int last);
    for (int i = first; i <= last; i++) wr_byte(i, 1'b1);
  endtask

  task automatic chk_status(input string tag, input bit rst_e, input bit ok_e, input bit err_e);
    chk({tag, "_core_reset"}, 32'(o_rst), 32'(rst_e));
    chk({tag, "_load_ok"}, 32'(o_ok), 32'(ok_e));
    chk({tag, "_load_err"}, 32'(o_err), 32'(err_e));
  endtask

  // Every cycle either pops the write due now or requires an idle write port.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("dn_wr", 32'(o_wr), 32'd1);
        chk("dn_addr", 32'(o_addr), 32'(e.a));
        chk("dn_data", 32'(o_data), 32'(e.d));
        chk("rgn_sel", 32'(o_rgn), 32'(e.r));
      end else begin
        chk("dn_wr_idle", 32'(o_wr), 32'd0);
        chk("rgn_idle", 32'(o_rgn), 32'd0);
      end
    end
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0; dl = 1'b0; wr = 1'b0; addr = '0; dout = '0;
    repeat (3) tick();
    rst_a = 1'b0; rst_b = 1'b0;
    mon_en = 1'b1;
    sample();
    chk_status("reset", 1'b1, 1'b0, 1'b0);
    chk("reset_state", 32'(o_state), 32'(S_BOOT));
    chk("reset_dn_addr", 32'(o_addr), 32'd0);
    chk("reset_dn_data", 32'(o_data), 32'd0);

    // Full image on the default-size instance; region boundaries checked per write.
    tick();
    dl = 1'b1;
    tick();
    load_seq(0, 49151);
    c0 = cyc;
    dl = 1'b0;
    tick();
    sample();
    chk_status("full_end", 1'b1, 1'b1, 1'b0);
    chk("full_state_hold", 32'(o_state), 32'(S_HOLD));
    run_until(c0 + 1024);
    sample();
    chk("full_hold_last", 32'(o_rst), 32'd1);
    run_until(c0 + 1025);
    sample();
    chk("full_release", 32'(o_rst), 32'd0);
    chk("full_state_run", 32'(o_state), 32'(S_RUN));
    chk("full_sb_drain", 32'(sb.size()), 32'd0);

    tick();
    sel = 1'b1;

    // Short image.
    dl = 1'b1;
    tick();
    load_seq(0, 255);
    c0 = cyc;
    dl = 1'b0;
    tick();
    sample();
    chk_status("short_end", 1'b1, 1'b0, 1'b1);
    run_until(c0 + SB_HOLD);
    sample();
    chk("short_state_hold", 32'(o_state), 32'(S_HOLD));
    run_until(c0 + SB_HOLD + 1);
    sample();
    chk("short_state_boot", 32'(o_state), 32'(S_BOOT));
    chk("short_core_reset", 32'(o_rst), 32'd1);

    // Address skip, then in-sequence bytes resume; one past the end is dropped.
    tick();
    dl = 1'b1;
    tick();
    sample();
    chk("skip_err_cleared", 32'(o_err), 32'd0);
    chk("skip_state_load", 32'(o_state), 32'(S_LOAD));
    load_seq(0, 255);
    wr_byte('h101, 1'b0);
    sample();
    chk("skip_err_set", 32'(o_err), 32'd1);
    load_seq('h100, 'h1FF);
    wr_byte('h200, 1'b0);
    c0 = cyc;
    dl = 1'b0;
    tick();
    sample();
    chk_status("skip_end", 1'b1, 1'b0, 1'b1);
    run_until(c0 + SB_HOLD + 1);
    sample();
    chk("skip_state_boot", 32'(o_state), 32'(S_BOOT));

    // Full load to run, writes ignored in run, then restart with byte 0 on the edge.
    tick();
    dl = 1'b1;
    tick();
    load_seq(0, SB_BYTES - 1);
    c0 = cyc;
    dl = 1'b0;
    tick();
    sample();
    chk_status("rl_first_end", 1'b1, 1'b1, 1'b0);
    run_until(c0 + SB_HOLD + 1);
    sample();
    chk("rl_run_state", 32'(o_state), 32'(S_RUN));
    chk("rl_run_reset", 32'(o_rst), 32'd0);
    wr_byte(5, 1'b0);
    sample();
    chk_status("rl_run_wr_ignored", 1'b0, 1'b1, 1'b0);
    dl = 1'b1;
    wr_byte(0, 1'b1);
    sample();
    chk_status("rl_restart", 1'b1, 1'b0, 1'b0);
    chk("rl_restart_state", 32'(o_state), 32'(S_LOAD));
    load_seq(1, SB_BYTES - 2);
    c0 = cyc;
    dl = 1'b0;
    wr_byte(SB_BYTES - 1, 1'b1);
    sample();
    chk_status("rl_fall_wr", 1'b1, 1'b1, 1'b0);
    chk("rl_fall_state", 32'(o_state), 32'(S_HOLD));
    run_until(c0 + SB_HOLD + 1);
    sample();
    chk("rl_rerun_state", 32'(o_state), 32'(S_RUN));
    chk("rl_rerun_reset", 32'(o_rst), 32'd0);

    // Reset mid-load with an error already latched.
    tick();
    dl = 1'b1;
    tick();
    load_seq(0, 'h2F);
    wr_byte('h40, 1'b0);
    rst_b = 1'b1;
    dl = 1'b0;
    wr_byte('h30, 1'b0);
    rst_b = 1'b0;
    sample();
    chk_status("midrst", 1'b1, 1'b0, 1'b0);
    chk("midrst_state", 32'(o_state), 32'(S_BOOT));
    chk("midrst_dn_addr", 32'(o_addr), 32'd0);
    chk("midrst_dn_data", 32'(o_data), 32'd0);

    tick();
    chk("final_sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_load_sequencer.md
Name: rom_load_sequencer

Overview:
- Sits between hps_io's ioctl download port and the Bagman core's dn_* ROM write port.
- Sequences each ROM download: registers and forwards write strobes, decodes the target region, counts bytes and checks address continuity.
- Holds the core in reset during loading and for a programmable tail afterwards. Replaces the ad-hoc initReset_n logic at top level.

Parameters:
- EXPECT_BYTES, 49152, exact byte count of a valid image (sum of all regions).
- HOLD_CYC, 1024, clk_sys cycles core_reset stays high after the download ends (min 1).
- CNT_W, 17, width of byte counter and dn_addr.

Ports:
- clk_sys  in  1  system clock (12 MHz).
- reset  in  1  synchronous, active-high; power-on only, never driven by the user reset.
- ioctl_download  in  1  download window active.
- ioctl_wr  in  1  one-cycle byte write strobe.
- ioctl_addr  in  25  byte address of the write.
- ioctl_dout  in  8  write data.
- dn_addr  out  CNT_W  registered address to the core.
- dn_data  out  8  registered data.
- dn_wr  out  1  registered write strobe, one cycle per accepted byte.
- rgn_sel  out  3  one-hot region of the current dn_wr: [0] CPU, [1] GFX, [2] SPEECH.
- core_reset  out  1  reset request to the core; top ORs it with status[0] and buttons[1].
- load_ok  out  1  sticky: last download was complete and continuous.
- load_err  out  1  sticky: last download was short, long or non-sequential.

Behaviour:
- Reset values: state=S_BOOT, dn_addr=0, dn_data=0, dn_wr=0, rgn_sel=0, core_reset=1, load_ok=0, load_err=0, byte count=0, hold counter=0.
- FSM states: S_BOOT, S_LOAD, S_HOLD, S_RUN.
- S_BOOT: core_reset=1. Rising edge of ioctl_download -> S_LOAD.
- S_LOAD:
  - core_reset=1. On entry: count=0, load_ok=0, load_err=0.
  - On ioctl_wr with ioctl_addr==count and count<EXPECT_BYTES: next cycle dn_wr=1, dn_addr=ioctl_addr[CNT_W-1:0], dn_data=ioctl_dout, rgn_sel decoded; count++. Latency is exactly 1 cycle.
  - On ioctl_wr with ioctl_addr!=count or addr>=EXPECT_BYTES: write dropped (dn_wr stays 0), load_err=1, count unchanged.
  - Falling edge of ioctl_download: if count==EXPECT_BYTES and no error, load_ok=1; else load_err=1. Then -> S_HOLD, hold counter=0.
- S_HOLD:
  - core_reset=1; hold counter increments each cycle.
  - When it reaches HOLD_CYC-1: if load_ok, -> S_RUN; else -> S_BOOT.
  - A download restart (rising ioctl_download) -> S_LOAD immediately.
- S_RUN: core_reset=0. Rising ioctl_download -> S_LOAD; core_reset=1 in the same cycle as the FSM update.
- Edge detection uses a one-cycle registered copy of ioctl_download. An ioctl_wr arriving on the falling-edge cycle is still processed before the completeness check.
- Simultaneous ioctl_wr and the rising edge: the write is processed against count=0.
- rgn_sel decode, from constants:
  - CPU 0x0000-0x5FFF
  - GFX 0x6000-0x9FFF
  - SPEECH 0xA000-0xBFFF
  - rgn_sel=0 whenever dn_wr=0.
- dn_wr never asserts outside S_LOAD. ioctl_wr is ignored in S_BOOT, S_HOLD and S_RUN, with no error set.
- count saturates at EXPECT_BYTES; no wrap.
- Reset mid-load: all state returns to reset values; any partial ROM contents in the core are irrelevant.

Decomposition:
- Package bagman_load_pkg holds:
  - state enum: S_BOOT, S_LOAD, S_HOLD, S_RUN
  - region base/limit constants: CPU_BASE, GFX_BASE, SPCH_BASE, IMG_END
  - region index localparams
- One sub-module, rom_region_decode: combinational address -> one-hot rgn_sel. It is reused by future multi-region cores.

Test Plan:
1. Reset, then a 49152-byte sequential download (addr 0..0xBFFF) -> 49152 dn_wr pulses, each 1 cycle after ioctl_wr. Expected after the falling edge: load_ok=1, load_err=0, core_reset falls exactly 1024 cycles later.
2. Region decode -> writes at 0x5FFF, 0x6000, 0x9FFF, 0xA000 give rgn_sel 001, 010, 010, 100.
3. Short download of 0x8000 bytes -> load_err=1, load_ok=0; after HOLD_CYC the FSM is in S_BOOT with core_reset still 1.
4. Address skip (0x0000-0x00FF, then 0x0101) -> 0x0101 write dropped with dn_wr=0, load_err=1; later in-sequence bytes are still forwarded.
5. Full load, then S_RUN, then a new download starts -> core_reset=1 on the edge cycle, load_ok cleared, reload completes, S_RUN re-entered.
6. Reset asserted mid-load at byte 0x3000 -> next cycle: core_reset=1, dn_wr=0, load_ok=0, load_err=0, state S_BOOT.
